// File: rtl/seven_segment_scan_decoder_pkg.sv
// Shared definitions for the seven-segment encode/decode path.
//   - SEG_0..SEG_F, SEG_BLANK : active-low {g,f,e,d,c,b,a} patterns (0 = segment on)
//   - seg_decode_t            : decode result {value, valid, error}
//   - is_one_hot()            : digit-select qualification helper
package seven_segment_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [3:0] value;
        logic       valid;
        logic       error;
    } seg_decode_t;

    // Callers zero-extend their select vector to 32 bits; extension does not
    // change one-hotness.
    function automatic logic is_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/seven_segment_scan_decoder_if.sv
// Bus bundle for the scan decoder.
//   digit_sel/seven_segment : scanned display bus (producer -> decoder)
//   hex_digits/digit_valid  : recovered digit state
//   evt_*                   : change-event port. evt_valid/evt_ready follow
//                             valid/ready: a transfer happens on each rising
//                             edge where both are 1; while evt_valid=1 and
//                             evt_ready=0 the payload is held stable.
// master = bus driver / event consumer, slave = decoder.
interface seven_segment_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [6:0]              seven_segment;
    logic [4*NUM_DIGITS-1:0] hex_digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    evt_valid;
    logic                    evt_ready;
    logic [IDX_W-1:0]        evt_digit;
    logic [3:0]              evt_value;
    logic                    evt_error;
    logic                    evt_overflow;

    modport master (
        output digit_sel, seven_segment, evt_ready,
        input  hex_digits, digit_valid, evt_valid, evt_digit,
               evt_value, evt_error, evt_overflow
    );

    modport slave (
        input  digit_sel, seven_segment, evt_ready,
        output hex_digits, digit_valid, evt_valid, evt_digit,
               evt_value, evt_error, evt_overflow
    );
endinterface

// File: rtl/seven_segment_scan_decoder_pattern_decoder.sv
// Combinational segment-pattern decoder.
//   i_pattern : active-low {g,f,e,d,c,b,a}
//   o_decode  : {value, valid, error}; blank -> all zero, unknown -> error=1
module seven_segment_pattern_decoder
    import seven_segment_pkg::*;
(
    input  logic [6:0]  i_pattern,
    output seg_decode_t o_decode
);

    always_comb begin
        o_decode.value = 4'h0;
        o_decode.valid = 1'b1;
        o_decode.error = 1'b0;
        case (i_pattern)
            SEG_0:     o_decode.value = 4'h0;
            SEG_1:     o_decode.value = 4'h1;
            SEG_2:     o_decode.value = 4'h2;
            SEG_3:     o_decode.value = 4'h3;
            SEG_4:     o_decode.value = 4'h4;
            SEG_5:     o_decode.value = 4'h5;
            SEG_6:     o_decode.value = 4'h6;
            SEG_7:     o_decode.value = 4'h7;
            SEG_8:     o_decode.value = 4'h8;
            SEG_9:     o_decode.value = 4'h9;
            SEG_A:     o_decode.value = 4'hA;
            SEG_B:     o_decode.value = 4'hB;
            SEG_C:     o_decode.value = 4'hC;
            SEG_D:     o_decode.value = 4'hD;
            SEG_E:     o_decode.value = 4'hE;
            SEG_F:     o_decode.value = 4'hF;
            SEG_BLANK: o_decode.valid = 1'b0;
            default: begin
                o_decode.valid = 1'b0;
                o_decode.error = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Seven-segment scan decoder: samples a multiplexed display bus, waits for
// STABLE_CYCLES identical samples, commits the decoded value into the selected
// digit and reports value changes through a single-entry event register.
//   i_clk     : rising-edge clock
//   i_reset_n : synchronous active-low reset
//   bus       : slave modport (scan inputs, digit state, event port)
module seven_segment_scan_decoder
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input logic                         i_clk,
    input logic                         i_reset_n,
    seven_segment_scan_decoder_if.slave bus
);

    localparam int         IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0]       r_s1_sel, r_s2_sel;
    logic [6:0]                  r_s1_seg, r_s2_seg;
    logic [7:0]                  r_stable_cnt;

    logic [NUM_DIGITS-1:0][3:0]  r_hex;
    logic [NUM_DIGITS-1:0]       r_valid;
    logic [NUM_DIGITS-1:0]       r_error;

    // Staging for a freshly generated event; it reaches the event register
    // one edge after the commit.
    logic                        r_new_pending;
    logic [IDX_W-1:0]            r_new_digit;
    logic [3:0]                  r_new_value;
    logic                        r_new_error;

    logic                        r_evt_valid;
    logic [IDX_W-1:0]            r_evt_digit;
    logic [3:0]                  r_evt_value;
    logic                        r_evt_error;
    logic                        r_evt_overflow;

    logic                        w_same;
    logic                        w_commit;
    logic                        w_sel_ok;
    logic [IDX_W-1:0]            w_idx;
    logic                        w_changed;
    seg_decode_t                 w_decode;

    seven_segment_pattern_decoder u_decoder (
        .i_pattern (r_s1_seg),
        .o_decode  (w_decode)
    );

    assign w_same   = (r_s1_sel == r_s2_sel) && (r_s1_seg == r_s2_seg);
    // Only the 7->8 step commits; once saturated the counter stays put.
    assign w_commit = w_same && (r_stable_cnt == STABLE_LAST);
    assign w_sel_ok = is_one_hot(32'(r_s1_sel));

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_s1_sel[i]) w_idx = IDX_W'(i);
        end
    end

    assign w_changed = ({r_hex[w_idx], r_valid[w_idx], r_error[w_idx]} != w_decode);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_s1_sel     <= '0;
            r_s1_seg     <= SEG_BLANK;
            r_s2_sel     <= '0;
            r_s2_seg     <= SEG_BLANK;
            r_stable_cnt <= 8'd0;
        end else begin
            r_s1_sel <= bus.digit_sel;
            r_s1_seg <= bus.seven_segment;
            r_s2_sel <= r_s1_sel;
            r_s2_seg <= r_s1_seg;
            if (!w_same)
                r_stable_cnt <= 8'd0;
            else if (r_stable_cnt < STABLE_MAX)
                r_stable_cnt <= r_stable_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_hex         <= '0;
            r_valid       <= '0;
            r_error       <= '0;
            r_new_pending <= 1'b0;
            r_new_digit   <= '0;
            r_new_value   <= 4'h0;
            r_new_error   <= 1'b0;
        end else begin
            r_new_pending <= w_commit && w_sel_ok && w_changed;
            if (w_commit && w_sel_ok) begin
                r_hex[w_idx]   <= w_decode.value;
                r_valid[w_idx] <= w_decode.valid;
                r_error[w_idx] <= w_decode.error;
                r_new_digit    <= w_idx;
                r_new_value    <= w_decode.value;
                r_new_error    <= w_decode.error;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_evt_valid    <= 1'b0;
            r_evt_digit    <= '0;
            r_evt_value    <= 4'h0;
            r_evt_error    <= 1'b0;
            r_evt_overflow <= 1'b0;
        end else if (r_new_pending && (!r_evt_valid || bus.evt_ready)) begin
            // Empty slot, or the current event leaves on this same edge.
            r_evt_valid <= 1'b1;
            r_evt_digit <= r_new_digit;
            r_evt_value <= r_new_value;
            r_evt_error <= r_new_error;
        end else begin
            if (r_new_pending)
                r_evt_overflow <= 1'b1;
            if (r_evt_valid && bus.evt_ready)
                r_evt_valid <= 1'b0;
        end
    end

    assign bus.hex_digits   = r_hex;
    assign bus.digit_valid  = r_valid;
    assign bus.evt_valid    = r_evt_valid;
    assign bus.evt_digit    = r_evt_digit;
    assign bus.evt_value    = r_evt_value;
    assign bus.evt_error    = r_evt_error;
    assign bus.evt_overflow = r_evt_overflow;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
module tb_seven_segment_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 8;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    seven_segment_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

    seven_segment_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected events: {digit[1:0], error, value[3:0]}
    logic [6:0] exp_q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference digit state
    logic [3:0] m_val [ND];
    logic       m_vld [ND];
    logic       m_err [ND];

    typedef struct {
        logic [3:0]  sel;
        logic [6:0]  seg;
        int          cycles;
        logic [15:0] exp_hex;
        logic [3:0]  exp_vld;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {value, valid, error}
    function automatic logic [5:0] ref_decode(input logic [6:0] seg);
        if (seg == 7'h7F) return 6'b0000_00;
        for (int i = 0; i < 16; i++) begin
            if (seg_tab[i] == seg) return {4'(i), 2'b10};
        end
        return 6'b0000_01;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_val[i] = 4'h0;
            m_vld[i] = 1'b0;
            m_err[i] = 1'b0;
        end
    endtask

    task automatic model_hold(input logic [3:0] sel, input logic [6:0] seg,
                              input int cycles, input bit drop);
        logic [5:0] d;
        int idx;
        if (cycles >= SC + 2 && $countones(sel) == 1) begin
            idx = 0;
            for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
            d = ref_decode(seg);
            if ({m_val[idx], m_vld[idx], m_err[idx]} != d) begin
                m_val[idx] = d[5:2];
                m_vld[idx] = d[1];
                m_err[idx] = d[0];
                if (!drop) exp_q.push_back({2'(idx), d[0], d[5:2]});
            end
        end
    endtask

    // Pattern present for edges 1..cycles after the drive; ends at the
    // falling edge after edge 'cycles'.
    task automatic hold_pattern(input logic [3:0] sel, input logic [6:0] seg,
                                input int cycles, input bit drop);
        @(posedge clk);
        #2;
        bus.digit_sel     = sel;
        bus.seven_segment = seg;
        model_hold(sel, seg, cycles, drop);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    // Event monitor: a transfer happens on the coming edge when both are high.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL evt_unexpected: got digit=%0d value=%0h error=%0b expected none",
                         bus.evt_digit, bus.evt_value, bus.evt_error);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if ({bus.evt_digit, bus.evt_error, bus.evt_value} !== e) begin
                    n_fail++;
                    $display("FAIL evt_payload: got %0h expected %0h",
                             {bus.evt_digit, bus.evt_error, bus.evt_value}, e);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{4'b0010, 7'h12, 5,  16'h0002, 4'b0001};
        vecs[1] = '{4'b0010, 7'h30, 12, 16'h0032, 4'b0011};
        vecs[2] = '{4'b0100, 7'h55, 12, 16'h0032, 4'b0011};
        vecs[3] = '{4'b0100, 7'h7F, 12, 16'h0032, 4'b0011};
        vecs[4] = '{4'b0011, 7'h00, 20, 16'h0032, 4'b0011};
        vecs[5] = '{4'b0000, 7'h00, 12, 16'h0032, 4'b0011};
        vecs[6] = '{4'b1000, 7'h0E, 12, 16'hF032, 4'b1011};
        vecs[7] = '{4'b0001, 7'h24, 12, 16'hF032, 4'b1011};
        vecs[8] = '{4'b1000, 7'h46, 12, 16'hC032, 4'b1011};
        vecs[9] = '{4'b0001, 7'h03, 12, 16'hC03B, 4'b1011};

        model_reset();

        // Reset with random bus activity
        reset_n           = 1'b0;
        bus.evt_ready     = 1'b1;
        bus.digit_sel     = 4'($urandom_range(0, 15));
        bus.seven_segment = 7'($urandom_range(0, 127));
        repeat (3) begin
            @(posedge clk);
            #2;
            bus.digit_sel     = 4'($urandom_range(0, 15));
            bus.seven_segment = 7'($urandom_range(0, 127));
        end
        @(negedge clk);
        check("rst_hex", 32'(bus.hex_digits), 32'h0);
        check("rst_valid", 32'(bus.digit_valid), 32'h0);
        check("rst_evt_valid", 32'(bus.evt_valid), 32'h0);
        check("rst_overflow", 32'(bus.evt_overflow), 32'h0);

        @(posedge clk);
        #2;
        reset_n           = 1'b1;
        bus.digit_sel     = 4'b0000;
        bus.seven_segment = 7'h7F;
        repeat (3) @(posedge clk);

        // Basic commit with exact latency
        @(posedge clk);
        #2;
        bus.digit_sel     = 4'b0001;
        bus.seven_segment = 7'h24;
        model_hold(4'b0001, 7'h24, 12, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 9) begin
                check("lat_hex_before", 32'(bus.hex_digits[3:0]), 32'h0);
                check("lat_valid_before", 32'(bus.digit_valid), 32'h0);
            end
            if (k == 10) begin
                check("lat_hex_commit", 32'(bus.hex_digits[3:0]), 32'h2);
                check("lat_valid_commit", 32'(bus.digit_valid), 32'h1);
                check("lat_evt_not_yet", 32'(bus.evt_valid), 32'h0);
            end
            if (k == 11) begin
                check("lat_evt_valid", 32'(bus.evt_valid), 32'h1);
                check("lat_evt_digit", 32'(bus.evt_digit), 32'h0);
                check("lat_evt_value", 32'(bus.evt_value), 32'h2);
                check("lat_evt_error", 32'(bus.evt_error), 32'h0);
            end
            if (k == 12) check("lat_evt_taken", 32'(bus.evt_valid), 32'h0);
        end

        // Table-driven vectors: glitch, illegal, blank, bad selects, duplicates
        for (int v = 0; v < 10; v++) begin
            hold_pattern(vecs[v].sel, vecs[v].seg, vecs[v].cycles, 1'b0);
            check($sformatf("vec%0d_hex", v), 32'(bus.hex_digits), 32'(vecs[v].exp_hex));
            check($sformatf("vec%0d_valid", v), 32'(bus.digit_valid), 32'(vecs[v].exp_vld));
            check($sformatf("vec%0d_evt_idle", v), 32'(bus.evt_valid), 32'h0);
            check($sformatf("vec%0d_overflow", v), 32'(bus.evt_overflow), 32'h0);
        end

        // Backpressure: first event held, second dropped
        @(posedge clk);
        #2;
        bus.evt_ready = 1'b0;
        hold_pattern(4'b0001, 7'h08, 12, 1'b0);
        hold_pattern(4'b0010, 7'h78, 12, 1'b1);
        check("bp_evt_valid", 32'(bus.evt_valid), 32'h1);
        check("bp_evt_digit", 32'(bus.evt_digit), 32'h0);
        check("bp_evt_value", 32'(bus.evt_value), 32'hA);
        check("bp_overflow", 32'(bus.evt_overflow), 32'h1);
        check("bp_hex", 32'(bus.hex_digits), 32'hC07A);
        @(posedge clk);
        #2;
        bus.evt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_drained", 32'(bus.evt_valid), 32'h0);
        check("bp_overflow_sticky", 32'(bus.evt_overflow), 32'h1);

        // Reset mid-operation discards a pending event
        @(posedge clk);
        #2;
        bus.evt_ready = 1'b0;
        hold_pattern(4'b0100, 7'h19, 12, 1'b1);
        check("mid_evt_pending", 32'(bus.evt_valid), 32'h1);
        check("mid_evt_value", 32'(bus.evt_value), 32'h4);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_evt", 32'(bus.evt_valid), 32'h0);
        check("mid_rst_overflow", 32'(bus.evt_overflow), 32'h0);
        check("mid_rst_hex", 32'(bus.hex_digits), 32'h0);
        @(posedge clk);
        #2;
        reset_n       = 1'b1;
        bus.evt_ready = 1'b1;
        hold_pattern(4'b0001, 7'h24, 12, 1'b0);
        check("post_rst_hex", 32'(bus.hex_digits), 32'h0002);
        check("post_rst_valid", 32'(bus.digit_valid), 32'h1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_decoder.md
Name: seven_segment_scan_decoder

Overview:
- Receive-side counterpart to the hex-to-segment encoder used on the DE2 display path.
- Samples a time-multiplexed seven-segment bus (one-hot digit select plus active-low {g,f,e,d,c,b,a}) and recovers the hex value of each digit.
- Filters glitches during digit scanning, and flags blank and illegal patterns.
- Reports each change of a digit's value through a single-entry valid/ready event port. Used for display loop-back checking and for snooping legacy display buses.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (width of digit_sel).
- STABLE_CYCLES, 8, number of consecutive identical samples required before a commit; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- digit_sel  in  NUM_DIGITS  one-hot, active-high select of the digit currently driven.
- seven_segment  in  7  {g,f,e,d,c,b,a}; 0 = segment on, 1 = segment off.
- hex_digits  out  4*NUM_DIGITS  recovered values; digit i occupies bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  1 = digit i holds a legal hex pattern.
- evt_valid  out  1  change event pending.
- evt_ready  in  1  consumer accepts the event.
- evt_digit  out  $clog2(NUM_DIGITS)  index of the changed digit.
- evt_value  out  4  new value of that digit; 0 if blank or illegal.
- evt_error  out  1  new pattern is illegal (neither hex nor blank).
- evt_overflow  out  1  sticky flag: an event was dropped while one was pending.

Behaviour:
- Reset: on a clock edge with reset_n=0, all outputs go to 0. Sample registers load digit_sel=0 and seven_segment=7'h7F. The stability counter goes to 0. Reset mid-operation discards any pending event.
- Input stage: two register levels. s1 captures {digit_sel, seven_segment}; s2 captures s1.
- Stability counter:
  - Reset to 0 when s1 != s2.
  - Otherwise increment, saturating at STABLE_CYCLES.
  - A commit occurs on the edge where the counter advances from STABLE_CYCLES-1 to STABLE_CYCLES. This gives exactly one commit per stable interval.
- Commit qualification: s1.digit_sel must be exactly one-hot. If it is zero or multi-hot, the commit is suppressed and no state changes.
- Latency: if inputs change before edge 1 and then stay constant, the commit happens on edge STABLE_CYCLES+2 (edge 10 at the default). Outputs are registered and visible after that edge.
- Pattern decode (combinational, on s1 segments):
  - The 16 encoder patterns map to values 0x0..0xF: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex, {g..a}).
  - 7'h7F decodes as blank: valid=0, error=0, value=0.
  - Any other pattern is illegal: valid=0, error=1, value=0.
- Commit update:
  - hex_digits[i] and digit_valid[i] are written for the selected digit i on every commit.
  - An event is generated only if the new {value, valid, error} differs from the stored state of digit i. Re-committing an identical pattern produces no event.
  - Per-digit error state is stored internally for this comparison.
- Event port:
  - Single-entry register. evt_valid rises on the edge after commit.
  - evt_digit, evt_value and evt_error stay stable while evt_valid=1 and evt_ready=0.
  - Transfer occurs on an edge where evt_valid=1 and evt_ready=1.
  - Event generated while pending, not accepted that cycle: the new event is dropped, evt_overflow is set, and the digit registers still update.
  - Accept and new event on the same edge: the new event loads and evt_valid stays 1; no overflow.
- evt_overflow is cleared only by reset.

Decomposition:
- Shared package (seven_segment_pkg), containing:
  - constants SEG_0..SEG_F and SEG_BLANK, also reused by the encoder;
  - the decode result struct {value[3:0], valid, error};
  - the is_one_hot helper.
- One natural sub-module: seven_segment_pattern_decoder. Combinational, pattern in, {value, valid, error} out. The top level holds the sampling, stability counter, digit registers and event logic.

Test Plan:
- Reset: hold reset_n=0 for 3 edges with random inputs -> hex_digits=0, digit_valid=0, evt_valid=0, evt_overflow=0.
- Basic commit: digit_sel=4'b0001, seg=7'h24 held 12 cycles, evt_ready=1 -> after edge 10, hex_digits[3:0]=2 and digit_valid=4'b0001. After edge 11, evt_valid=1 for one cycle with evt_digit=0, evt_value=2, evt_error=0.
- Glitch reject: digit_sel=4'b0010 with seg=7'h12 for 5 cycles, then seg=7'h30 for 12 cycles -> only value 3 commits on digit 1. No event with value 5.
- Illegal/blank:
  - seg=7'h55 stable on digit 2 -> digit_valid[2]=0, event with evt_error=1, evt_value=0.
  - Then seg=7'h7F -> event with evt_error=0, evt_value=0.
- Backpressure: evt_ready=0; commit 0xA on digit 0, then 0x7 on digit 1 -> first event held (evt_digit=0, evt_value=A) and evt_overflow=1. hex_digits shows both A and 7.
- Select filtering and duplicates:
  - digit_sel=4'b0011 stable for 20 cycles -> no commit and no event.
  - Digit 0 re-shows 7'h24 after a different digit was scanned -> no new event.
